// File: rtl/sipo.sv
// ---------------------------------------------------------------------------
// Module  : sipo
// Purpose : Bidirectional serial-in / parallel-out shift register with a
//           word-complete strobe and a bit counter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sipo #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             direction,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    bit_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

  logic             last_dir;
  logic             dir_known;
  logic             restart;
  logic             word_done;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] shift_next;

  // A direction change abandons the partial word; the edge's bit becomes bit 1.
  // dir_known masks the first edge after reset so it never counts as a change.
  always_comb begin
    restart    = dir_known && (direction != last_dir);
    count_next = restart ? CW'(1) : bit_count + CW'(1);
    word_done  = (count_next == FULL_COUNT);
    shift_next = direction ? {dout[WIDTH-2:0], din} : {din, dout[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      bit_count  <= '0;
      last_dir   <= 1'b0;
      dir_known  <= 1'b0;
    end else begin
      dout       <= shift_next;
      dout_valid <= word_done;
      bit_count  <= word_done ? '0 : count_next;
      last_dir   <= direction;
      dir_known  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sipo.sv
// ---------------------------------------------------------------------------
// Module  : tb_sipo
// Purpose : Self-checking bench for sipo: directed vector table, async reset
//           sequence and randomized run against a word-level reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sipo;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             direction;
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    bit_count;

  int checks;
  int failures;

  sipo #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .direction  (direction),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .bit_count  (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             r;
    logic             dir;
    logic             d;
    logic [WIDTH-1:0] e_dout;
    logic             e_valid;
    logic [CW-1:0]    e_cnt;
    string            name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [WIDTH-1:0] ed,
                       input logic ev, input logic [CW-1:0] ec);
    checks++;
    if (dout !== ed || dout_valid !== ev || bit_count !== ec) begin
      failures++;
      $display("FAIL %s: got dout=%b valid=%b count=%0d, expected dout=%b valid=%b count=%0d",
               nm, dout, dout_valid, bit_count, ed, ev, ec);
    end
  endtask

  // Drive inputs 1 time unit after a rising edge, clock once, sample 1 unit later.
  task automatic step(input logic r, input logic dir, input logic d);
    rst       = r;
    direction = dir;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic dir, input logic d,
                     input logic [WIDTH-1:0] ed, input logic ev,
                     input logic [CW-1:0] ec, input string nm);
    vec_t v;
    v.r = r; v.dir = dir; v.d = d;
    v.e_dout = ed; v.e_valid = ev; v.e_cnt = ec; v.name = nm;
    tbl.push_back(v);
  endtask

  // Word-level reference model state
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  int               m_len;
  int               m_dir;

  task automatic model_reset();
    m_dout  = '0;
    m_valid = 1'b0;
    m_len   = 0;
    m_dir   = -1;
  endtask

  task automatic model_edge(input logic dir, input logic d);
    if (m_dir >= 0 && int'(dir) != m_dir) m_len = 0;
    m_dir = int'(dir);
    m_len = m_len + 1;
    if (dir) m_dout = (m_dout << 1) | WIDTH'(d);
    else     m_dout = (m_dout >> 1) | (WIDTH'(d) << (WIDTH - 1));
    if (m_len == WIDTH) begin
      m_valid = 1'b1;
      m_len   = 0;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    direction = 1'b1;
    din       = 1'b0;

    // reset held with din toggling
    add(0, 1, 1, 4'b0000, 0, 0, "reset0");
    add(0, 1, 0, 4'b0000, 0, 0, "reset1");
    // left shift word
    add(1, 1, 1, 4'b0001, 0, 1, "left1");
    add(1, 1, 0, 4'b0010, 0, 2, "left2");
    add(1, 1, 1, 4'b0101, 0, 3, "left3");
    add(1, 1, 0, 4'b1010, 1, 0, "left4");
    // right shift word, direction change restarts count at 1
    add(1, 0, 0, 4'b0101, 0, 1, "right1");
    add(1, 0, 1, 4'b1010, 0, 2, "right2");
    add(1, 0, 0, 4'b0101, 0, 3, "right3");
    add(1, 0, 1, 4'b1010, 1, 0, "right4");
    // continuous left stream of 10 bits
    add(1, 1, 1, 4'b0101, 0, 1, "stream1");
    add(1, 1, 0, 4'b1010, 0, 2, "stream2");
    add(1, 1, 1, 4'b0101, 0, 3, "stream3");
    add(1, 1, 0, 4'b1010, 1, 0, "stream4");
    add(1, 1, 1, 4'b0101, 0, 1, "stream5");
    add(1, 1, 0, 4'b1010, 0, 2, "stream6");
    add(1, 1, 1, 4'b0101, 0, 3, "stream7");
    add(1, 1, 0, 4'b1010, 1, 0, "stream8");
    add(1, 1, 1, 4'b0101, 0, 1, "stream9");
    add(1, 1, 0, 4'b1010, 0, 2, "stream10");
    // mid-word direction flip
    add(0, 1, 0, 4'b0000, 0, 0, "flip_rst");
    add(1, 1, 1, 4'b0001, 0, 1, "flip_l1");
    add(1, 1, 1, 4'b0011, 0, 2, "flip_l2");
    add(1, 0, 0, 4'b0001, 0, 1, "flip_r1");
    add(1, 0, 1, 4'b1000, 0, 2, "flip_r2");
    add(1, 0, 1, 4'b1100, 0, 3, "flip_r3");
    add(1, 0, 0, 4'b0110, 1, 0, "flip_r4");
    // mid-word reset discards the partial word
    add(0, 1, 0, 4'b0000, 0, 0, "mr_rst0");
    add(1, 1, 1, 4'b0001, 0, 1, "mr_a1");
    add(1, 1, 1, 4'b0011, 0, 2, "mr_a2");
    add(1, 1, 1, 4'b0111, 0, 3, "mr_a3");
    add(0, 1, 1, 4'b0000, 0, 0, "mr_rst1");
    add(1, 1, 1, 4'b0001, 0, 1, "mr_b1");
    add(1, 1, 0, 4'b0010, 0, 2, "mr_b2");
    add(1, 1, 1, 4'b0101, 0, 3, "mr_b3");
    add(1, 1, 1, 4'b1011, 1, 0, "mr_b4");

    @(posedge clk);
    #1;
    check("reset_initial", '0, 1'b0, '0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].dir, tbl[i].d);
      check(tbl[i].name, tbl[i].e_dout, tbl[i].e_valid, tbl[i].e_cnt);
    end

    // Asynchronous reset between edges, landing on a dout_valid cycle
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    check("async_pre", 4'b1011, 1'b1, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_clear", '0, 1'b0, '0);
    @(posedge clk);
    #1;
    check("async_hold", '0, 1'b0, '0);

    // Randomized run against the reference model
    model_reset();
    direction = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r, dir, d;
      r   = ($urandom_range(0, 39) != 0);
      dir = ($urandom_range(0, 3) == 0) ? ~direction : direction;
      d   = 1'($urandom);
      step(r, dir, d);
      if (!r) model_reset();
      else    model_edge(dir, d);
      check($sformatf("rand%0d", n), m_dout, m_valid, CW'(m_len));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sipo.md
Name: sipo

Overview:
Bidirectional serial-in, parallel-out shift register. One serial bit is captured per clock, and the full WIDTH-bit word is presented in parallel. A word-complete strobe and a bit counter let downstream logic sample whole words. The block sits at a serial receive edge (e.g. after a bit-sync stage), feeding a parallel datapath.

Parameters:
- WIDTH, 4, parallel word width in bits (legal range 2..32).
- CW, $clog2(WIDTH+1), width of bit_count (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- direction  input  1  1 = shift left (din enters the LSB); 0 = shift right (din enters the MSB).
- din  input  1  serial data bit, sampled every rising clk edge.
- dout  output  WIDTH  parallel shift-register contents (registered).
- dout_valid  output  1  one-cycle strobe: dout holds WIDTH bits shifted in one direction since the last word boundary.
- bit_count  output  CW  number of bits shifted into the current word, 0..WIDTH-1.
- Port order is fixed: clk, rst, direction, din, dout, dout_valid, bit_count. Benches may connect only the first five positionally; the trailing outputs may be left open.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk): dout=0, dout_valid=0, bit_count=0. Outputs hold these values while rst=0.
- Normal operation (rst=1): a shift occurs on every rising clk edge. There is no enable.
  - direction=1: dout <= {dout[WIDTH-2:0], din}.
  - direction=0: dout <= {din, dout[WIDTH-1:1]}.
- Latency: din sampled at edge N is visible on dout immediately after edge N (1-cycle register latency).
- direction is sampled on the same edge as din. A change in direction takes effect on the first edge where it is sampled. Existing dout contents are not cleared; they keep shifting in the new direction.
- bit_count:
  - Increments on each shift.
  - When the shift makes the count reach WIDTH, bit_count wraps to 0 and dout_valid=1 for exactly that following cycle. Otherwise dout_valid=0.
  - If direction differs from its value on the previous shift edge, the current word is abandoned: bit_count restarts at 1 (this edge's bit counts as the first) and no dout_valid is produced for the partial word.
  - The word restart does not alter the dout shift itself.
- After reset release, the "previous direction" register is treated as matching the first sampled direction, so no spurious restart occurs.
- Reset asserted mid-word: the partial word is discarded and the next word starts from bit_count=0.
- X on din propagates into dout only; control state (bit_count, dout_valid) does not depend on din.

Decomposition:
- No shared package needed. WIDTH is a module parameter.
- Single flat module; no sub-module. Internal state is the shift register, the bit counter, and a 1-bit last-direction register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with din toggling -> dout=0000, dout_valid=0, bit_count=0. Assert rst between clock edges -> outputs clear immediately.
- Left shift: release rst; direction=1, din=1,0,1,0 on four edges -> dout=0001, 0010, 0101, 1010; bit_count=1,2,3,0; dout_valid=1 only after the 4th edge.
- Right shift: from dout=1010, direction=0, din=0,1,0,1 -> dout=0101, 1010, 0101, 1010; the direction change restarts bit_count at 1, giving 1,2,3,0; dout_valid pulses after the 4th edge.
- Continuous stream: direction=1, 10 edges alternating din=1,0 -> dout_valid pulses after edges 4 and 8 only; final dout=1010.
- Mid-word direction flip: direction=1 for 2 bits, then direction=0 -> no dout_valid for the partial word; bit_count=1 after the flip edge; dout is shifted right with the prior contents retained.
- Mid-word reset: after 3 left shifts, pulse rst=0 -> dout=0 and bit_count=0; the next word needs a full 4 shifts before dout_valid.
